// File: rtl/dac80004_pkg.sv
// Shared types, DAC80004 command/address codes and frame packing for the SPI transmitter.
package dac80004_pkg;

    typedef enum logic [2:0] {IDLE, START, SHIFT, STOP, GAP} tx_state_t;

    localparam logic [3:0] CMD_WRITE_BUF        = 4'h0;
    localparam logic [3:0] CMD_UPDATE           = 4'h1;
    localparam logic [3:0] CMD_WRITE_UPDATE_ALL = 4'h2;
    localparam logic [3:0] CMD_WRITE_UPDATE     = 4'h3;
    localparam logic [3:0] CMD_POWER            = 4'h4;
    localparam logic [3:0] CMD_CLEAR            = 4'h5;
    localparam logic [3:0] CMD_LDAC             = 4'h6;
    localparam logic [3:0] CMD_RESET            = 4'h7;

    localparam logic [3:0] ADDR_A   = 4'h0;
    localparam logic [3:0] ADDR_B   = 4'h1;
    localparam logic [3:0] ADDR_C   = 4'h2;
    localparam logic [3:0] ADDR_D   = 4'h3;
    localparam logic [3:0] ADDR_ALL = 4'hF;

    function automatic logic [31:0] pack_frame(input logic [3:0]  cmd,
                                               input logic [3:0]  addr,
                                               input logic [15:0] data);
        return {4'b0000, cmd, addr, data, 4'b0000};
    endfunction

endpackage

// File: rtl/dac80004_spi_tx.sv
// Tick-paced SPI transmitter for the DAC80004: one 32-bit frame per handshake, MSB first.
module dac80004_spi_tx
    import dac80004_pkg::*;
#(
    parameter int unsigned GAP_TICKS  = 2,
    parameter int unsigned FRAME_BITS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [3:0]  cmd,
    input  logic [3:0]  addr,
    input  logic [15:0] data,
    input  logic        valid,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        sync_n,
    output logic        sclk,
    output logic        sdi
);

    localparam int unsigned GapW = $clog2(GAP_TICKS + 1);

    tx_state_t         state;
    logic [31:0]       shreg;
    logic [4:0]        bit_cnt;
    logic              phase;
    logic [GapW-1:0]   gap_cnt;

    assign ready = (state == IDLE);
    assign busy  = ~ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            gap_cnt <= '0;
            done    <= 1'b0;
            sync_n  <= 1'b1;
            sclk    <= 1'b0;
            sdi     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                // tick is deliberately ignored here, even in the accept cycle
                IDLE: begin
                    if (valid) begin
                        shreg   <= pack_frame(cmd, addr, data);
                        bit_cnt <= 5'(FRAME_BITS - 1);
                        phase   <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        sync_n <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            sclk  <= 1'b1;
                            sdi   <= shreg[31];
                            shreg <= {shreg[30:0], 1'b0};
                            phase <= 1'b1;
                        end else begin
                            sclk  <= 1'b0;
                            phase <= 1'b0;
                            if (bit_cnt == 5'd0) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt - 5'd1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        sync_n  <= 1'b1;
                        sdi     <= 1'b0;
                        done    <= 1'b1;
                        gap_cnt <= GapW'(GAP_TICKS - 1);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - GapW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac80004_spi_tx.sv
// Scoreboard bench for dac80004_spi_tx: stimulus queues expected frames, a monitor decodes the SPI bus.
module tb_dac80004_spi_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  cmd = '0;
    logic [3:0]  addr = '0;
    logic [15:0] data = '0;
    logic        valid = 1'b0;
    logic        ready, busy, done, sync_n, sclk, sdi;
    logic        tick;

    int          tick_period = 25;
    logic        tick_hi = 1'b0;
    int          div_cnt = 0;

    int          errs = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int          frame_cnt = 0;
    logic [31:0] exp_q[$];

    dac80004_spi_tx #(.GAP_TICKS(2), .FRAME_BITS(32)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .cmd(cmd), .addr(addr), .data(data),
        .valid(valid), .ready(ready), .busy(busy), .done(done), .sync_n(sync_n),
        .sclk(sclk), .sdi(sdi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div_cnt >= tick_period - 1) div_cnt <= 0;
        else div_cnt <= div_cnt + 1;
    end
    assign tick = tick_hi || (div_cnt == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus monitor: decodes frames from sync_n/sclk/sdi and checks them against the queue.
    initial begin
        logic        prev_sync = 1'b1;
        logic        prev_sclk = 1'b0;
        logic [31:0] rx = '0;
        int          nbits = 0, nrise = 0, lowticks = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_sync = 1'b1;
                prev_sclk = 1'b0;
                nbits = 0; nrise = 0; lowticks = 0; rx = '0;
            end else begin
                if (done) done_cnt++;
                if (!sync_n && prev_sync) begin
                    rx = '0; nbits = 0; nrise = 0; lowticks = 0;
                end
                if (!sync_n) begin
                    if (sclk && !prev_sclk) nrise++;
                    if (!sclk && prev_sclk) begin
                        rx = {rx[30:0], sdi};
                        nbits++;
                    end
                    if (tick) lowticks++;
                end
                if (sync_n && !prev_sync) begin
                    frame_cnt++;
                    check("done_at_sync_rise", 32'(done), 32'd1);
                    check("frame_queued", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("frame_data", rx, exp_q.pop_front());
                    check("sclk_falls", 32'(nbits), 32'd32);
                    check("sclk_rises", 32'(nrise), 32'd32);
                    check("sync_low_ticks", 32'(lowticks), 32'd65);
                end
                prev_sync = sync_n;
                prev_sclk = sclk;
            end
        end
    end

    task automatic wait_ready(input int limit);
        for (int i = 0; i < limit && !ready; i++) @(negedge clk);
        check("ready_seen", 32'(ready), 32'd1);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !done; i++) @(negedge clk);
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic send(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        wait_ready(5000);
        cmd = c; addr = a; data = d; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    initial begin
        int n;
        int d0;
        int rises;
        logic ps;

        // Reset state
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sync_n", 32'(sync_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_sdi", 32'(sdi), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single frame at tick/25
        d0 = done_cnt;
        exp_q.push_back(32'h030A55A0);
        send(4'h3, 4'h0, 16'hA55A);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done(3000);
        n = 0;
        for (int i = 0; i < 500 && !ready; i++) begin
            if (tick) n++;
            @(negedge clk);
        end
        check("gap_ticks_to_ready", 32'(n), 32'd2);
        check("single_done_count", 32'(done_cnt - d0), 32'd1);

        // Back-to-back with valid held high
        d0 = done_cnt;
        exp_q.push_back(32'h03000010);
        exp_q.push_back(32'h030FFFF0);
        send(4'h3, 4'h0, 16'h0001);
        valid = 1'b1;
        @(negedge clk);
        data = 16'hFFFF;
        wait_done(3000);
        n = 0;
        for (int i = 0; i < 500; i++) begin
            if (tick) n++;
            if (ready) begin
                @(posedge clk);
                #1 check("b2b_accept_first_ready", 32'(ready), 32'd0);
                valid = 1'b0;
            end
            @(negedge clk);
            if (!sync_n) break;
        end
        valid = 1'b0;
        check("b2b_high_ticks", 32'(n), 32'd3);
        wait_done(3000);
        @(negedge clk);
        wait_ready(500);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

        // valid pulsed during SHIFT is ignored
        d0 = done_cnt;
        exp_q.push_back(32'h0321234 << 4);
        send(4'h3, 4'h2, 16'h1234);
        for (int i = 0; i < 500 && !sclk; i++) @(negedge clk);
        data = 16'hBEEF; valid = 1'b1;
        @(posedge clk);
        #1 check("ignored_valid_ready", 32'(ready), 32'd0);
        valid = 1'b0;
        wait_done(3000);
        @(negedge clk);
        wait_ready(500);
        repeat (60) @(negedge clk);
        check("ignored_not_queued", 32'(ready), 32'd1);
        check("ignored_done_count", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset mid-frame
        send(4'h3, 4'h1, 16'hFFFF);
        rises = 0;
        ps = sclk;
        for (int i = 0; i < 3000 && rises < 10; i++) begin
            @(negedge clk);
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        d0 = done_cnt;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_sync_n", 32'(sync_n), 32'd1);
        check("arst_sclk", 32'(sclk), 32'd0);
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q.push_back(32'h02F80010);
        send(4'h2, 4'hF, 16'h8001);
        wait_done(3000);
        @(negedge clk);
        wait_ready(500);
        check("arst_next_frame_done", 32'(done_cnt - d0), 32'd1);

        // tick held high: sclk = clk/2
        tick_hi = 1'b1;
        exp_q.push_back(32'h0315A5A0);
        send(4'h3, 4'h1, 16'h5A5A);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            n++;
            #1 if (ready) break;
        end
        check("tick_high_frame_clks", 32'(n), 32'd68);
        tick_hi = 1'b0;

        // tick coinciding with the accept cycle
        exp_q.push_back(32'h00200FF0);
        @(negedge clk);
        for (int i = 0; i < 200 && !(tick && ready); i++) @(negedge clk);
        check("accept_tick_aligned", 32'(tick && ready), 32'd1);
        cmd = 4'h0; addr = 4'h2; data = 16'h00FF; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        check("accept_tick_no_start", 32'(sync_n), 32'd1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            n++;
            #1 if (!sync_n) break;
        end
        check("sync_fall_next_tick", 32'(n), 32'd25);
        wait_done(3000);
        @(negedge clk);
        wait_ready(500);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("frames_total", 32'(frame_cnt), 32'd7);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
